vga_stream_timing_gen: RTL and testbench

Parametrised successor to the fixed 640x480 HDMI pixel front end. Generates programmable raster timing (porches, sync widths, sync polarity) and pulls pixels from a standard (non-FWFT) FIFO. Input pixels are RGB565 or RGB888, and the block always outputs RGB888. Underflow is tracked per frame: stream recovery happens only at the next frame start, and underflow events are counted for status. Sits between the camera frame FIFO and the TMDS encoder.

---
 rtl/vga_stream_timing_gen.sv | 172 +++++++++++++++++
 tb/tb_vga_stream_timing_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vga_stream_timing_gen.sv
// Programmable raster timing generator that streams RGB565/RGB888 pixels from a non-FWFT FIFO.
// Optional PATTERN_FALLBACK_EN shows colour bars instead of FILL_RGB while not streaming.
module vga_stream_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned IN_W     = 16,
  parameter logic [23:0] FILL_RGB = 24'h000000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [IN_W-1:0] fifo_data_in,
  input  logic            fifo_empty,
  output logic            fifo_read_en,
  output logic            hsync,
  output logic            vsync,
  output logic            data_enable,
  output logic [23:0]     rgb,
  output logic            frame_start,
  output logic            streaming,
  output logic [15:0]     underflow_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  typedef enum logic [1:0] {StWait, StStream, StDrop} state_e;

  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;
  state_e        state_q, state_d;
  logic          active, hs_act, vs_act, fs, entry, pop, underflow;
  logic          de_q, hs_q, vs_q, fs_q, pop_q;
  logic [23:0]   pix_in, fill_px;

  always_comb begin
    active = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    hs_act = (32'(h_q) >= H_ACTIVE + H_FP) && (32'(h_q) < H_ACTIVE + H_FP + H_SYNC);
    vs_act = (32'(v_q) >= V_ACTIVE + V_FP) && (32'(v_q) < V_ACTIVE + V_FP + V_SYNC);
    fs     = (h_q == '0) && (v_q == '0);
    entry  = enable & ~fifo_empty;
  end

  // At frame start only the entry condition may pop, so a frame heading to WAIT never pops.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    underflow = 1'b0;
    if (fs) begin
      state_d = entry ? StStream : StWait;
      pop     = active & entry;
    end else if (state_q == StStream && active) begin
      if (fifo_empty) begin
        underflow = 1'b1;
        state_d   = StDrop;
      end else begin
        pop = 1'b1;
      end
    end
  end

  assign fifo_read_en = pop & ~reset;
  assign streaming    = (state_q == StStream);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_q             <= '0;
      v_q             <= '0;
      state_q         <= StWait;
      underflow_count <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (h_q == HW'(H_TOTAL - 1)) begin
        h_q <= '0;
        v_q <= (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
      end else begin
        h_q <= h_q + HW'(1);
      end
      if (underflow && underflow_count != 16'hFFFF) begin
        underflow_count <= underflow_count + 16'h0001;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      de_q  <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      fs_q  <= 1'b0;
      pop_q <= 1'b0;
    end else begin
      de_q  <= active;
      hs_q  <= hs_act;
      vs_q  <= vs_act;
      fs_q  <= fs;
      pop_q <= pop;
    end
  end

  generate
    if (IN_W == 16) begin : g_rgb565
      assign pix_in = {fifo_data_in[15:11], fifo_data_in[15:13],
                       fifo_data_in[10:5],  fifo_data_in[10:9],
                       fifo_data_in[4:0],   fifo_data_in[4:2]};
    end else begin : g_rgb888
      assign pix_in = fifo_data_in[23:0];
    end
  endgenerate

`ifdef PATTERN_FALLBACK_EN
  logic [2:0] bar_q;
  logic       idle_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bar_q  <= 3'd0;
      idle_q <= 1'b0;
    end else begin
      bar_q  <= 3'((32'(h_q) << 3) / H_ACTIVE);
      idle_q <= (state_q != StStream);
    end
  end

  // Underflow pixels inside STREAM keep the plain fill colour.
  always_comb begin
    fill_px = FILL_RGB;
    if (idle_q) begin
      unique case (bar_q)
        3'd0: fill_px = 24'hFFFFFF;
        3'd1: fill_px = 24'hFFFF00;
        3'd2: fill_px = 24'h00FFFF;
        3'd3: fill_px = 24'h00FF00;
        3'd4: fill_px = 24'hFF00FF;
        3'd5: fill_px = 24'hFF0000;
        3'd6: fill_px = 24'h0000FF;
        3'd7: fill_px = 24'h000000;
        default: fill_px = FILL_RGB;
      endcase
    end
  end
`else
  assign fill_px = FILL_RGB;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      data_enable <= 1'b0;
      frame_start <= 1'b0;
      rgb         <= 24'h000000;
    end else begin
      hsync       <= hs_q ? HS_POL : ~HS_POL;
      vsync       <= vs_q ? VS_POL : ~VS_POL;
      data_enable <= de_q;
      frame_start <= fs_q;
      rgb         <= pop_q ? pix_in : (de_q ? fill_px : 24'h000000);
    end
  end

endmodule

// File: tb/tb_vga_stream_timing_gen.sv
// Self-checking bench for vga_stream_timing_gen on a 14x7 raster with table-driven RGB565 words.
module tb_vga_stream_timing_gen;

  localparam int          HT      = 14;
  localparam int          VT      = 7;
  localparam logic [23:0] FILL    = 24'h123456;
  localparam logic [27:0] RST_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};

  typedef struct {
    logic [15:0] word;
    logic [23:0] rgb;
  } vec_t;

  vec_t        tbl [8];
`ifdef PATTERN_FALLBACK_EN
  logic [23:0] bars [8];
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_data_in = 16'h0000;
  logic        fifo_read_en, hsync, vsync, data_enable, frame_start, streaming;
  logic [23:0] rgb;
  logic [15:0] underflow_count;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          src = 0;
  int          pops = 0;
  bit          m_stream = 1'b0;
  logic [15:0] m_uf = 16'h0000;
  logic [27:0] exp_d1 = RST_VEC;
  logic [27:0] exp_d2 = RST_VEC;

  vga_stream_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .IN_W(16), .FILL_RGB(FILL)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .fifo_data_in   (fifo_data_in),
    .fifo_empty     (fifo_empty),
    .fifo_read_en   (fifo_read_en),
    .hsync          (hsync),
    .vsync          (vsync),
    .data_enable    (data_enable),
    .rgb            (rgb),
    .frame_start    (frame_start),
    .streaming      (streaming),
    .underflow_count(underflow_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // One pixel clock: compare at negedge, deliver FIFO data one clock after the pop.
  task automatic cycle();
    int          ph, pv;
    bit          act, fs, exp_re, re_seen;
    logic [23:0] px;
    logic [27:0] now;
    @(negedge clock);
    ph     = cyc % HT;
    pv     = (cyc / HT) % VT;
    act    = (ph < 8) && (pv < 4);
    fs     = (ph == 0) && (pv == 0);
    exp_re = act && !fifo_empty && (fs ? enable : m_stream);
    if (exp_re) begin
      px = tbl[src % 8].rgb;
    end else if (act) begin
      px = FILL;
`ifdef PATTERN_FALLBACK_EN
      if (!m_stream) px = bars[ph];
`endif
    end else begin
      px = 24'h000000;
    end
    now = {!(ph >= 10 && ph < 12), !(pv == 5), act, fs, px};
    check("outputs", {hsync, vsync, data_enable, frame_start, rgb}, exp_d2);
    check("ctrl", {fifo_read_en, streaming, underflow_count}, {exp_re, m_stream, m_uf});
    re_seen = fifo_read_en;
    @(posedge clock);
    #1;
    if (re_seen) begin
      fifo_data_in = tbl[src % 8].word;
      src++;
      pops++;
    end
    if (fs) begin
      m_stream = enable && !fifo_empty;
    end else if (m_stream && act && fifo_empty) begin
      m_stream = 1'b0;
      if (m_uf != 16'hFFFF) m_uf = m_uf + 16'h0001;
    end
    exp_d2 = exp_d1;
    exp_d1 = now;
    cyc++;
  endtask

  task automatic run_frame(input string name, input bit en, input int en_off_at,
                           input bit base_empty, input int empty_at, input int exp_pops,
                           input logic [15:0] exp_uf);
    pops = 0;
    for (int i = 0; i < HT * VT; i++) begin
      enable     = (en_off_at >= 0 && i >= en_off_at) ? 1'b0 : en;
      fifo_empty = base_empty || (i == empty_at);
      cycle();
    end
    check({name, "_pops"}, 64'(pops), 64'(exp_pops));
    check({name, "_underflow_count"}, 64'(underflow_count), 64'(exp_uf));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check("reset_outputs", {hsync, vsync, data_enable, frame_start, rgb}, RST_VEC);
    check("reset_ctrl", {fifo_read_en, streaming, underflow_count}, 18'h0);
    @(posedge clock);
    #1;
    check("reset_hold", {hsync, vsync, data_enable, frame_start, rgb, fifo_read_en}, {RST_VEC, 1'b0});
    reset    = 1'b0;
    cyc      = 0;
    m_stream = 1'b0;
    m_uf     = 16'h0000;
    exp_d1   = RST_VEC;
    exp_d2   = RST_VEC;
  endtask

  initial begin
    tbl[0] = '{16'hF800, 24'hFF0000};
    tbl[1] = '{16'h07E0, 24'h00FF00};
    tbl[2] = '{16'h001F, 24'h0000FF};
    tbl[3] = '{16'hFFFF, 24'hFFFFFF};
    tbl[4] = '{16'h0000, 24'h000000};
    tbl[5] = '{16'h8410, 24'h848284};
    tbl[6] = '{16'h1234, 24'h1045A5};
    tbl[7] = '{16'h7BEF, 24'h7B7D7B};
`ifdef PATTERN_FALLBACK_EN
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif
    #2;
    pulse_reset();

    for (int f = 0; f < 3; f++) run_frame("empty", 1'b1, -1, 1'b1, -1, 0, 16'd0);
    run_frame("stream_a", 1'b1, -1, 1'b0, -1, 32, 16'd0);
    run_frame("stream_b", 1'b1, -1, 1'b0, -1, 32, 16'd0);
    // Empty for one clock at pixel 3 of line 1.
    run_frame("underflow", 1'b1, -1, 1'b0, 17, 11, 16'd1);
    run_frame("resume", 1'b1, -1, 1'b0, -1, 32, 16'd1);
    run_frame("fs_empty", 1'b1, -1, 1'b0, 0, 0, 16'd1);
    run_frame("en_off_cur", 1'b1, 40, 1'b0, -1, 32, 16'd1);
    run_frame("en_off_next", 1'b0, -1, 1'b0, -1, 0, 16'd1);

    enable     = 1'b1;
    fifo_empty = 1'b0;
    for (int i = 0; i < 2 * HT + 2; i++) cycle();
    pulse_reset();
    run_frame("after_reset", 1'b1, -1, 1'b0, -1, 32, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
